wb_uart_tx: RTL and testbench
=============================

# wb_uart_tx

Wishbone slave UART transmitter that sits on the `xm_cpu` data bus beside `mem_wishbone`, downstream of the CPU's bus master port. The CPU writes bytes into a small FIFO. An 8N1 serialiser with a programmable bit period drains the FIFO onto `tx_o`. The upstream address decoder gates `stb_i`, so the block decodes only the low word-address bits.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `DEFAULT_DIV`, default 16'd868: reset value of the BAUD register, in clock cycles per bit.
- `clk_i` in 1: system clock; all state changes on the rising edge.
- `arst_i` in 1: reset. Asynchronous, active-high.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe, already qualified by the address decoder.
- `we_i` in 1: write enable.
- `sel_i` in 2: byte selects; bit0 selects `dat_i[7:0]`, bit1 selects `dat_i[15:8]`.
- `adr_i` in 15: word address; only `adr_i[1:0]` is decoded.
- `dat_i` in 16: write data.
- `ack_o` out 1: single-cycle acknowledge.
- `dat_o` out 16: read data; valid while `ack_o` is high, 0 otherwise.
- `tx_o` out 1: serial line; idles high.
- `irq_o` out 1: level; high when the FIFO is empty and the serialiser is idle.

## Operation
- Register map by `adr_i[1:0]`:
  - 0 DATA: write-only.
    - A write with `sel_i[0]`=1 pushes `dat_i[7:0]`.
    - A write with `sel_i[0]`=0 is ignored.
    - Reads return 0.
  - 1 STATUS: read-only fields.
    - [0] busy, [1] full, [2] empty, [3] overflow (sticky).
    - [7:4] FIFO count.
    - Any write clears overflow.
  - 2 BAUD: read/write, byte-enabled per `sel_i`.
    - A value of 0 is treated as 1.
  - 3: reads 0; writes ignored.
- Bus handshake:
  - At each edge, `ack_o` <= `cyc_i & stb_i & !ack_o`. The request is sampled and takes effect on that same edge.
  - `ack_o` is never high two consecutive cycles.
  - `ack_o` stays low whenever `cyc_i` or `stb_i` is low.
  - Every access is acknowledged, including dropped writes.
- FIFO:
  - A push when full is dropped and sets overflow, except when a pop occurs on the same edge. In that case the push is accepted and the count stays `DEPTH`.
  - Pointers wrap modulo `DEPTH`.
- Serialiser FSM:
  - States: IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE, FIFO non-empty: pop the head into the shift register, then go to START.
  - START: `tx_o`=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each.
  - STOP: `tx_o`=1 for one bit period. At the end of STOP, pop and go to START if the FIFO is non-empty; otherwise go to IDLE.
  - Back-to-back bytes have no idle gap.
- Bit timer:
  - Loaded with max(BAUD,1)-1 at each bit start, then counts down. The bit ends at 0.
  - A BAUD write mid-frame takes effect at the next bit boundary.
- busy = (state != IDLE).

## Timing
- Reset values:
  - `ack_o`=0, `dat_o`=0, `tx_o`=1, `irq_o`=1.
  - FIFO empty, overflow=0, BAUD=`DEFAULT_DIV`, state IDLE.
- Reset asserted mid-frame:
  - `tx_o` goes high immediately, without waiting for a clock edge.
  - FIFO contents are discarded.
- Write latency:
  - Edge E0 samples the DATA write: `ack_o`=1 and count=1.
  - Edge E1, with the FSM idle: pop, `tx_o`=0, `irq_o`=0.
- Frame length: 10×max(BAUD,1) cycles (11× with parity).
- `irq_o` rises on the edge that enters IDLE with the FIFO empty.
- Registered outputs: `tx_o`, `ack_o`, `dat_o`; `irq_o` is combinational from state and count.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for one bit period.
  - Frame length is 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state; the frame is 8N1 (10 bits).

## Test plan
- Reset, then read STATUS -> `dat_o`=16'h0004 in the ack cycle; `tx_o`=1; `irq_o`=1.
- Write BAUD=4, then write DATA=8'hA5 -> `tx_o` sequence, 4 cycles per bit, starting one edge after the ack edge: 0, 1,0,1,0,0,1,0,1, 1; `irq_o` goes high after the 40th cycle.
- Write BAUD=2, then 5 back-to-back DATA writes (`DEPTH`=4) while the first byte is still in START:
  - All 5 are acked.
  - 5 frames are sent with no idle gap between them.
  - Overflow stays 0, because the first pop freed a slot.
- Write BAUD=100, write 6 bytes fast -> the 6th is dropped; STATUS reads full=1, overflow=1, count=4. A write to STATUS then clears overflow.
- Assert `arst_i` mid-DATA of a frame -> `tx_o`=1 immediately; after release, STATUS=16'h0004 and BAUD=`DEFAULT_DIV`.
- Hold `cyc_i`=`stb_i`=1 for 4 cycles -> `ack_o` pattern 1,0,1,0 (two accesses). With `stb_i`=0, `ack_o` stays 0.

Source files
------------

// File: rtl/wb_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx_if
// Purpose  : Wishbone slave bus bundle for the wb_uart_tx transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_uart_tx_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic [14:0] adr_i;
    logic [15:0] dat_i;
    logic        ack_o;
    logic [15:0] dat_o;

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o
    );

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx
// Purpose  : Wishbone slave UART transmitter, byte FIFO feeding an 8N1
//            serialiser. Define UART_TX_PARITY_EN to add an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_tx #(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  wire logic        clk_i,
    input  wire logic        arst_i,
    wb_uart_tx_if.slave      bus,
    output logic             tx_o,
    output logic             irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic            ack_q;
    logic [15:0]     dat_q, dat_d;
    logic            tx_q, tx_d;
    logic [15:0]     baud_q, baud_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;

    logic            w_req, w_wr, w_push, w_push_ok, w_pop;
    logic            w_full, w_empty;
    logic [7:0]      w_head;
    logic [15:0]     w_div_m1, w_cnt_ext, w_status, w_rdata;
    logic            w_unused_adr;

    assign w_unused_adr = ^bus.adr_i[14:2];

    // The request is taken on the edge it is sampled; ack blocks a second one.
    assign w_req     = bus.cyc_i & bus.stb_i & ~ack_q;
    assign w_wr      = w_req & bus.we_i;
    assign w_push    = w_wr & (bus.adr_i[1:0] == 2'd0) & bus.sel_i[0];
    assign w_full    = (count_q == CW'(DEPTH));
    assign w_empty   = (count_q == '0);
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_head    = mem_q[rd_ptr_q];
    assign w_div_m1  = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;
    assign w_cnt_ext = 16'(count_q);
    assign w_status  = {8'h00, w_cnt_ext[3:0], ovf_q, w_empty, w_full, (state_q != S_IDLE)};

    always_comb begin
        w_rdata = 16'h0000;
        case (bus.adr_i[1:0])
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = baud_q;
            default: w_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        dat_d  = (w_req & ~bus.we_i) ? w_rdata : 16'h0000;
        baud_d = baud_q;
        if (w_wr && bus.adr_i[1:0] == 2'd2) begin
            if (bus.sel_i[0]) baud_d[7:0]  = bus.dat_i[7:0];
            if (bus.sel_i[1]) baud_d[15:8] = bus.dat_i[15:8];
        end
        ovf_d = ovf_q;
        if (w_wr && bus.adr_i[1:0] == 2'd1)
            ovf_d = 1'b0;
        else if (w_push && w_full && !w_pop)
            ovf_d = 1'b1;
        count_d = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_head;
                    par_d   = ^w_head;
                    timer_d = w_div_m1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == 16'd0) begin
                    timer_d = w_div_m1;
                    idx_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = w_div_m1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (timer_q == 16'd0) begin
                    timer_d = w_div_m1;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == 16'd0) begin
                    // Chain straight into the next start bit so frames abut.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shreg_d = w_head;
                        par_d   = ^w_head;
                        timer_d = w_div_m1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 16'h0000;
            tx_q     <= 1'b1;
            baud_q   <= DEFAULT_DIV;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= 16'd0;
            idx_q    <= 3'd0;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= w_req;
            dat_q    <= dat_d;
            tx_q     <= tx_d;
            baud_q   <= baud_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= bus.dat_i[7:0];
    end

    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;
    assign tx_o      = tx_q;
    assign irq_o     = (state_q == S_IDLE) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_tx
// Purpose  : Self-checking bench for wb_uart_tx against a bit-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_tx;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] DEF_DIV = 16'd868;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b0;
    logic tx_o, irq_o;

    int vectors = 0;
    int errors  = 0;

    bit         exp_q[$];
    logic [7:0] tx_bytes[$];

    wb_uart_tx_if bus();

    wb_uart_tx #(.DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus),
        .tx_o   (tx_o),
        .irq_o  (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [1:0] sel,
                           input logic [15:0] wdat, output logic [15:0] rdat);
        bit got = 0;
        rdat = 16'hxxxx;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = {13'd0, adr}; bus.sel_i = sel; bus.dat_i = wdat;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk_i); #1;
            if (bus.ack_o === 1'b1) begin
                got  = 1;
                rdat = bus.dat_o;
            end
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL wb_ack: no ack within 4 cycles (adr=%0d we=%0b), expected ack", adr, we);
        end
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [1:0] sel, input logic [15:0] wdat);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr, sel, wdat, dummy);
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [15:0] rdat);
        wb_xfer(1'b0, adr, 2'b11, 16'h0000, rdat);
    endtask

    task automatic check_reg(input logic [1:0] adr, input logic [15:0] exp, input string name);
        logic [15:0] rd;
        wb_read(adr, rd);
        vectors++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL %s: read 0x%04h, expected 0x%04h", name, rd, exp);
        end
    endtask

    // Reference frame: each line bit held for div cycles.
    function automatic void push_frame(input logic [7:0] b, input int div);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int c = 0; c < div; c++) exp_q.push_back(bits[i]);
    endfunction

    task automatic run_stream(input int div, input string name);
        exp_q.delete();
        foreach (tx_bytes[i]) push_frame(tx_bytes[i], div);
        wb_write(2'd0, 2'b01, {8'($urandom), tx_bytes[0]});
        fork
            begin
                for (int i = 1; i < tx_bytes.size(); i++)
                    wb_write(2'd0, {1'($urandom), 1'b1}, {8'($urandom), tx_bytes[i]});
            end
            begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    @(posedge clk_i); #1;
                    vectors++;
                    if (tx_o !== exp_q[i] || irq_o !== 1'b0) begin
                        errors++;
                        $display("FAIL %s cycle %0d: tx_o=%b irq_o=%b, expected tx_o=%b irq_o=0",
                                 name, i, tx_o, irq_o, exp_q[i]);
                    end
                end
                @(posedge clk_i); #1;
                vectors++;
                if (tx_o !== 1'b1 || irq_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s end: tx_o=%b irq_o=%b, expected 1 1", name, tx_o, irq_o);
                end
            end
        join
    endtask

    task automatic test_reset;
        #3;
        vectors++;
        if (tx_o !== 1'b1 || irq_o !== 1'b1 || bus.ack_o !== 1'b0 || bus.dat_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b irq=%b ack=%b dat=0x%04h, expected 1 1 0 0x0000",
                     tx_o, irq_o, bus.ack_o, bus.dat_o);
        end
        #20 arst_i = 1'b0;
        @(posedge clk_i); #1;
        check_reg(2'd1, 16'h0004, "reset_status");
        check_reg(2'd2, DEF_DIV, "reset_baud");
        check_reg(2'd0, 16'h0000, "data_reads_zero");
        check_reg(2'd3, 16'h0000, "reg3_reads_zero");
        wb_write(2'd0, 2'b10, 16'h5A5A);
        check_reg(2'd1, 16'h0004, "data_sel0_clear_ignored");
        vectors++;
        if (tx_o !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: tx=%b irq=%b, expected 1 1", tx_o, irq_o);
        end
    endtask

    task automatic test_single_frame;
        wb_write(2'd2, 2'b11, 16'd4);
        tx_bytes.delete();
        tx_bytes.push_back(8'hA5);
        run_stream(4, "frame_a5");
    endtask

    task automatic test_back_to_back;
        wb_write(2'd2, 2'b11, 16'd2);
        tx_bytes.delete();
        for (int i = 0; i < DEPTH + 1; i++) tx_bytes.push_back(8'($urandom));
        run_stream(2, "back_to_back");
        check_reg(2'd1, 16'h0004, "b2b_no_overflow");
    endtask

    task automatic test_overflow;
        wb_write(2'd2, 2'b11, 16'd100);
        for (int i = 0; i < DEPTH + 2; i++) wb_write(2'd0, 2'b01, 16'h0000);
        check_reg(2'd1, 16'h004B, "overflow_status");
        wb_write(2'd1, 2'b11, 16'hFFFF);
        check_reg(2'd1, 16'h0043, "overflow_cleared");
    endtask

    task automatic test_async_reset;
        repeat (150) @(posedge clk_i);
        #1;
        vectors++;
        if (tx_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_data_tx: tx_o=%b, expected 0", tx_o);
        end
        #3 arst_i = 1'b1;
        #1;
        vectors++;
        if (tx_o !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: tx=%b irq=%b, expected 1 1", tx_o, irq_o);
        end
        #22 arst_i = 1'b0;
        @(posedge clk_i); #1;
        check_reg(2'd1, 16'h0004, "post_reset_status");
        check_reg(2'd2, DEF_DIV, "post_reset_baud");
    endtask

    task automatic test_ack_pattern;
        @(posedge clk_i); #1;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = 15'd1; bus.sel_i = 2'b11; bus.dat_i = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            vectors++;
            if (bus.ack_o !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL ack_pattern[%0d]: ack=%b, expected %b", k, bus.ack_o, (k % 2) == 0);
            end
        end
        bus.stb_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            vectors++;
            if (bus.ack_o !== 1'b0 || bus.dat_o !== 16'h0000) begin
                errors++;
                $display("FAIL ack_no_stb[%0d]: ack=%b dat=0x%04h, expected 0 0x0000",
                         k, bus.ack_o, bus.dat_o);
            end
        end
        bus.cyc_i = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] baud;
        int          div;
        for (int it = 0; it < 6; it++) begin
            baud = 16'($urandom_range(0, 5));
            div  = (baud == 16'd0) ? 1 : int'(baud);
            wb_write(2'd2, 2'b11, baud);
            check_reg(2'd2, baud, "random_baud_rb");
            tx_bytes.delete();
            for (int i = 0; i < int'($urandom_range(1, DEPTH + 1)); i++)
                tx_bytes.push_back(8'($urandom));
            run_stream(div, "random_stream");
        end
    endtask

    initial begin
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.sel_i = 2'b00; bus.adr_i = 15'd0; bus.dat_i = 16'h0000;
        #1 arst_i = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random();
        test_ack_pattern();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
